// File: rtl/cvxif_pkg.sv
// Shared CV-X-IF types for the result tracker.
//   X_ID_WIDTH     : width of an offload instruction id
//   x_result_t     : coprocessor result payload (id, data, rd, we)
//   entry_state_e  : per-id tracking state
package cvxif_pkg;

    localparam int unsigned X_ID_WIDTH = 4;
    localparam int unsigned X_RFW      = 32;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [X_RFW-1:0]      data;
        logic [4:0]            rd;
        logic                  we;
    } x_result_t;

    typedef enum logic [2:0] {
        EntIdle,
        EntIssued,
        EntIssuedNowb,
        EntCommitted,
        EntKilled
    } entry_state_e;

endpackage

// File: rtl/cvxif_result_tracker.sv
// Tracks every offloaded id from issue through commit to result, forwards
// results of committed instructions to the core through a one-slot register
// and drops results of killed ones.
// Ports:
//   clk_i, rst_ni                       clock, synchronous active-low reset
//   issue_*_i                           issue handshake and response
//   commit_valid_i/commit_id_i/kill_i   commit channel
//   x_result_valid_i/x_result_i/_o      result channel from coprocessor
//   flush_i                             pipeline flush, drops all tracking
//   wb_valid_o/wb_ready_i/wb_o          writeback channel to the core
//   outstanding_o/full_o                number of non-idle entries, all busy
//   err_o                               sticky protocol error
module cvxif_result_tracker
    import cvxif_pkg::*;
#(
    parameter int unsigned NR_IDS = 2 ** X_ID_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  issue_valid_i,
    input  logic                  issue_ready_i,
    input  logic [X_ID_WIDTH-1:0] issue_id_i,
    input  logic                  issue_accept_i,
    input  logic                  issue_writeback_i,
    input  logic                  commit_valid_i,
    input  logic [X_ID_WIDTH-1:0] commit_id_i,
    input  logic                  commit_kill_i,
    input  logic                  x_result_valid_i,
    input  x_result_t             x_result_i,
    output logic                  x_result_ready_o,
    input  logic                  flush_i,
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output x_result_t             wb_o,
    output logic [X_ID_WIDTH:0]   outstanding_o,
    output logic                  full_o,
    output logic                  err_o
);

    localparam int unsigned CntW = X_ID_WIDTH + 1;

    entry_state_e state_q [NR_IDS];
    entry_state_e state_d [NR_IDS];
    logic         wb_valid_q, wb_valid_d;
    x_result_t    wb_q, wb_d;
    logic         err_q;
    logic         err_set;
    logic         load;
    logic         issue_fire;
    logic         res_fire;
    logic [CntW-1:0] cnt;

    // Flush keeps the result channel draining so nothing stalls behind it.
    assign x_result_ready_o = !wb_valid_q || wb_ready_i || flush_i;
    assign issue_fire       = issue_valid_i && issue_ready_i && issue_accept_i;
    assign res_fire         = x_result_valid_i && x_result_ready_o;

    // Per entry: commit, then result against post-commit state, then issue
    // against post-release state. A release and re-issue in one cycle is legal.
    always_comb begin
        entry_state_e st;
        st      = EntIdle;
        err_set = 1'b0;
        load    = 1'b0;
        for (int unsigned i = 0; i < NR_IDS; i++) begin
            st = state_q[i];
            if (commit_valid_i && commit_id_i == X_ID_WIDTH'(i)) begin
                case (st)
                    EntIssued:     st = commit_kill_i ? EntKilled : EntCommitted;
                    EntIssuedNowb: st = EntIdle;
                    default:       err_set = 1'b1;
                endcase
            end
            if (res_fire && x_result_i.id == X_ID_WIDTH'(i)) begin
                case (st)
                    EntCommitted: begin
                        load = 1'b1;
                        st   = EntIdle;
                    end
                    EntKilled: st = EntIdle;
                    default:   err_set = 1'b1;
                endcase
            end
            if (issue_fire && issue_id_i == X_ID_WIDTH'(i)) begin
                if (st != EntIdle) begin
                    err_set = 1'b1;
                end
                st = issue_writeback_i ? EntIssued : EntIssuedNowb;
            end
            state_d[i] = st;
        end
        // Flush overrides every same-cycle event, including error detection.
        if (flush_i) begin
            for (int unsigned i = 0; i < NR_IDS; i++) begin
                state_d[i] = EntIdle;
            end
            err_set = 1'b0;
            load    = 1'b0;
        end
    end

    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_d       = wb_q;
        if (load) begin
            wb_valid_d = 1'b1;
            wb_d       = x_result_i;
        end else if (wb_ready_i || flush_i) begin
            wb_valid_d = 1'b0;
        end
    end

    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < NR_IDS; i++) begin
            if (state_q[i] != EntIdle) begin
                cnt = cnt + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NR_IDS; i++) begin
                state_q[i] <= EntIdle;
            end
            wb_valid_q <= 1'b0;
            wb_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NR_IDS; i++) begin
                state_q[i] <= state_d[i];
            end
            wb_valid_q <= wb_valid_d;
            wb_q       <= wb_d;
            err_q      <= err_q || err_set;
        end
    end

    assign wb_valid_o    = wb_valid_q;
    assign wb_o          = wb_q;
    assign outstanding_o = cnt;
    assign full_o        = (cnt == CntW'(NR_IDS));
    assign err_o         = err_q;

endmodule

// File: tb/tb_cvxif_result_tracker.sv
// Directed self-checking bench for cvxif_result_tracker.
module tb_cvxif_result_tracker;
    import cvxif_pkg::*;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic                  issue_valid_i, issue_ready_i, issue_accept_i, issue_writeback_i;
    logic [X_ID_WIDTH-1:0] issue_id_i;
    logic                  commit_valid_i, commit_kill_i;
    logic [X_ID_WIDTH-1:0] commit_id_i;
    logic                  x_result_valid_i;
    x_result_t             x_result_i;
    logic                  x_result_ready_o;
    logic                  flush_i;
    logic                  wb_valid_o, wb_ready_i;
    x_result_t             wb_o;
    logic [X_ID_WIDTH:0]   outstanding_o;
    logic                  full_o, err_o;

    int n_vec  = 0;
    int n_miss = 0;

    cvxif_result_tracker dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .issue_valid_i     (issue_valid_i),
        .issue_ready_i     (issue_ready_i),
        .issue_id_i        (issue_id_i),
        .issue_accept_i    (issue_accept_i),
        .issue_writeback_i (issue_writeback_i),
        .commit_valid_i    (commit_valid_i),
        .commit_id_i       (commit_id_i),
        .commit_kill_i     (commit_kill_i),
        .x_result_valid_i  (x_result_valid_i),
        .x_result_i        (x_result_i),
        .x_result_ready_o  (x_result_ready_o),
        .flush_i           (flush_i),
        .wb_valid_o        (wb_valid_o),
        .wb_ready_i        (wb_ready_i),
        .wb_o              (wb_o),
        .outstanding_o     (outstanding_o),
        .full_o            (full_o),
        .err_o             (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic do_issue(input logic [X_ID_WIDTH-1:0] id, input logic wb);
        issue_valid_i = 1'b1; issue_ready_i = 1'b1; issue_accept_i = 1'b1;
        issue_id_i = id; issue_writeback_i = wb;
        tick();
        issue_valid_i = 1'b0;
    endtask

    task automatic do_commit(input logic [X_ID_WIDTH-1:0] id, input logic kill);
        commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
        tick();
        commit_valid_i = 1'b0; commit_kill_i = 1'b0;
    endtask

    task automatic set_result(input logic [X_ID_WIDTH-1:0] id, input logic [31:0] data);
        x_result_valid_i = 1'b1;
        x_result_i.id = id; x_result_i.data = data; x_result_i.rd = 5'd1; x_result_i.we = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++; if (wb_valid_o !== 1'b0) begin n_miss++; $display("FAIL rst_wb_valid: got %b want 0", wb_valid_o); end
        n_vec++; if (wb_o !== '0) begin n_miss++; $display("FAIL rst_wb_o: got %h want 0", wb_o); end
        n_vec++; if (outstanding_o !== 5'd0) begin n_miss++; $display("FAIL rst_out: got %0d want 0", outstanding_o); end
        n_vec++; if (full_o !== 1'b0) begin n_miss++; $display("FAIL rst_full: got %b want 0", full_o); end
        n_vec++; if (err_o !== 1'b0) begin n_miss++; $display("FAIL rst_err: got %b want 0", err_o); end
        n_vec++; if (x_result_ready_o !== 1'b1) begin n_miss++; $display("FAIL rst_ready: got %b want 1", x_result_ready_o); end
    endtask

    task automatic test_forward();
        wb_ready_i = 1'b1;
        do_issue(4'd3, 1'b1);
        n_vec++; if (outstanding_o !== 5'd1) begin n_miss++; $display("FAIL fwd_out_issue: got %0d want 1", outstanding_o); end
        do_commit(4'd3, 1'b0);
        n_vec++; if (outstanding_o !== 5'd1) begin n_miss++; $display("FAIL fwd_out_commit: got %0d want 1", outstanding_o); end
        set_result(4'd3, 32'hDEAD);
        n_vec++; if (x_result_ready_o !== 1'b1) begin n_miss++; $display("FAIL fwd_ready: got %b want 1", x_result_ready_o); end
        n_vec++; if (wb_valid_o !== 1'b0) begin n_miss++; $display("FAIL fwd_wb_early: got %b want 0", wb_valid_o); end
        tick();
        x_result_valid_i = 1'b0;
        n_vec++; if (wb_valid_o !== 1'b1) begin n_miss++; $display("FAIL fwd_wb_valid: got %b want 1", wb_valid_o); end
        n_vec++; if (wb_o.data !== 32'hDEAD) begin n_miss++; $display("FAIL fwd_wb_data: got %h want dead", wb_o.data); end
        n_vec++; if (wb_o.id !== 4'd3) begin n_miss++; $display("FAIL fwd_wb_id: got %0d want 3", wb_o.id); end
        n_vec++; if (outstanding_o !== 5'd0) begin n_miss++; $display("FAIL fwd_out_done: got %0d want 0", outstanding_o); end
        tick();
        n_vec++; if (wb_valid_o !== 1'b0) begin n_miss++; $display("FAIL fwd_wb_drain: got %b want 0", wb_valid_o); end
        n_vec++; if (err_o !== 1'b0) begin n_miss++; $display("FAIL fwd_err: got %b want 0", err_o); end
    endtask

    task automatic test_kill();
        wb_ready_i = 1'b1;
        do_issue(4'd5, 1'b1);
        do_commit(4'd5, 1'b1);
        n_vec++; if (outstanding_o !== 5'd1) begin n_miss++; $display("FAIL kill_out: got %0d want 1", outstanding_o); end
        set_result(4'd5, 32'h5555);
        n_vec++; if (x_result_ready_o !== 1'b1) begin n_miss++; $display("FAIL kill_ready: got %b want 1", x_result_ready_o); end
        tick();
        x_result_valid_i = 1'b0;
        n_vec++; if (wb_valid_o !== 1'b0) begin n_miss++; $display("FAIL kill_wb_valid: got %b want 0", wb_valid_o); end
        n_vec++; if (err_o !== 1'b0) begin n_miss++; $display("FAIL kill_err: got %b want 0", err_o); end
        n_vec++; if (outstanding_o !== 5'd0) begin n_miss++; $display("FAIL kill_out_done: got %0d want 0", outstanding_o); end
    endtask

    task automatic test_back_to_back();
        wb_ready_i = 1'b0;
        do_issue(4'd1, 1'b1);
        do_issue(4'd2, 1'b1);
        do_commit(4'd1, 1'b0);
        do_commit(4'd2, 1'b0);
        n_vec++; if (outstanding_o !== 5'd2) begin n_miss++; $display("FAIL b2b_out: got %0d want 2", outstanding_o); end
        set_result(4'd1, 32'h1111);
        tick();
        x_result_valid_i = 1'b0;
        n_vec++; if (wb_valid_o !== 1'b1 || wb_o.data !== 32'h1111) begin n_miss++; $display("FAIL b2b_first: got %b/%h want 1/1111", wb_valid_o, wb_o.data); end
        n_vec++; if (x_result_ready_o !== 1'b0) begin n_miss++; $display("FAIL b2b_stall_ready: got %b want 0", x_result_ready_o); end
        set_result(4'd2, 32'h2222);
        for (int k = 0; k < 2; k++) begin
            tick();
            n_vec++; if (wb_valid_o !== 1'b1 || wb_o.data !== 32'h1111) begin n_miss++; $display("FAIL b2b_hold: got %b/%h want 1/1111", wb_valid_o, wb_o.data); end
            n_vec++; if (outstanding_o !== 5'd1) begin n_miss++; $display("FAIL b2b_hold_out: got %0d want 1", outstanding_o); end
        end
        wb_ready_i = 1'b1;
        #1;
        n_vec++; if (x_result_ready_o !== 1'b1) begin n_miss++; $display("FAIL b2b_ready_go: got %b want 1", x_result_ready_o); end
        tick();
        x_result_valid_i = 1'b0;
        n_vec++; if (wb_valid_o !== 1'b1 || wb_o.data !== 32'h2222) begin n_miss++; $display("FAIL b2b_second: got %b/%h want 1/2222", wb_valid_o, wb_o.data); end
        n_vec++; if (outstanding_o !== 5'd0) begin n_miss++; $display("FAIL b2b_out_done: got %0d want 0", outstanding_o); end
        tick();
        n_vec++; if (wb_valid_o !== 1'b0) begin n_miss++; $display("FAIL b2b_drain: got %b want 0", wb_valid_o); end
        n_vec++; if (err_o !== 1'b0) begin n_miss++; $display("FAIL b2b_err: got %b want 0", err_o); end
    endtask

    task automatic test_full();
        wb_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            do_issue(X_ID_WIDTH'(i), 1'b1);
        end
        n_vec++; if (outstanding_o !== 5'd16) begin n_miss++; $display("FAIL full_out: got %0d want 16", outstanding_o); end
        n_vec++; if (full_o !== 1'b1) begin n_miss++; $display("FAIL full_flag: got %b want 1", full_o); end
        // Commit and result to id 0 in the same cycle.
        commit_valid_i = 1'b1; commit_id_i = 4'd0; commit_kill_i = 1'b0;
        set_result(4'd0, 32'h00A0);
        tick();
        commit_valid_i = 1'b0; x_result_valid_i = 1'b0;
        n_vec++; if (outstanding_o !== 5'd15) begin n_miss++; $display("FAIL full_rel_out: got %0d want 15", outstanding_o); end
        n_vec++; if (full_o !== 1'b0) begin n_miss++; $display("FAIL full_rel_flag: got %b want 0", full_o); end
        n_vec++; if (wb_valid_o !== 1'b1 || wb_o.data !== 32'h00A0) begin n_miss++; $display("FAIL full_rel_wb: got %b/%h want 1/a0", wb_valid_o, wb_o.data); end
        // Release and re-issue of id 1 in the same cycle.
        commit_valid_i = 1'b1; commit_id_i = 4'd1; commit_kill_i = 1'b0;
        set_result(4'd1, 32'h00A1);
        issue_valid_i = 1'b1; issue_ready_i = 1'b1; issue_accept_i = 1'b1;
        issue_id_i = 4'd1; issue_writeback_i = 1'b1;
        tick();
        commit_valid_i = 1'b0; x_result_valid_i = 1'b0; issue_valid_i = 1'b0;
        n_vec++; if (outstanding_o !== 5'd15) begin n_miss++; $display("FAIL reuse_out: got %0d want 15", outstanding_o); end
        n_vec++; if (wb_valid_o !== 1'b1 || wb_o.data !== 32'h00A1) begin n_miss++; $display("FAIL reuse_wb: got %b/%h want 1/a1", wb_valid_o, wb_o.data); end
        n_vec++; if (err_o !== 1'b0) begin n_miss++; $display("FAIL reuse_err: got %b want 0", err_o); end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        n_vec++; if (outstanding_o !== 5'd0 || full_o !== 1'b0) begin n_miss++; $display("FAIL full_flush: got %0d/%b want 0/0", outstanding_o, full_o); end
    endtask

    task automatic test_flush();
        wb_ready_i = 1'b0;
        do_issue(4'd8, 1'b1);
        do_commit(4'd8, 1'b0);
        set_result(4'd8, 32'h0088);
        tick();
        x_result_valid_i = 1'b0;
        for (int i = 9; i < 13; i++) begin
            do_issue(X_ID_WIDTH'(i), 1'b1);
        end
        n_vec++; if (outstanding_o !== 5'd4 || wb_valid_o !== 1'b1) begin n_miss++; $display("FAIL fl_setup: got %0d/%b want 4/1", outstanding_o, wb_valid_o); end
        n_vec++; if (x_result_ready_o !== 1'b0) begin n_miss++; $display("FAIL fl_ready_pre: got %b want 0", x_result_ready_o); end
        flush_i = 1'b1;
        #1;
        n_vec++; if (x_result_ready_o !== 1'b1) begin n_miss++; $display("FAIL fl_ready: got %b want 1", x_result_ready_o); end
        tick();
        flush_i = 1'b0;
        n_vec++; if (outstanding_o !== 5'd0) begin n_miss++; $display("FAIL fl_out: got %0d want 0", outstanding_o); end
        n_vec++; if (wb_valid_o !== 1'b0) begin n_miss++; $display("FAIL fl_wb: got %b want 0", wb_valid_o); end
        n_vec++; if (err_o !== 1'b0) begin n_miss++; $display("FAIL fl_err: got %b want 0", err_o); end
        // Same scenario ended by reset, with a deliverable result in flight.
        do_issue(4'd8, 1'b1);
        do_issue(4'd9, 1'b1);
        do_commit(4'd8, 1'b0);
        do_commit(4'd9, 1'b0);
        set_result(4'd8, 32'h0088);
        tick();
        x_result_valid_i = 1'b0;
        n_vec++; if (wb_valid_o !== 1'b1 || outstanding_o !== 5'd1) begin n_miss++; $display("FAIL rs_setup: got %b/%0d want 1/1", wb_valid_o, outstanding_o); end
        rst_ni = 1'b0; wb_ready_i = 1'b1;
        set_result(4'd9, 32'h0099);
        tick();
        x_result_valid_i = 1'b0; rst_ni = 1'b1;
        n_vec++; if (outstanding_o !== 5'd0) begin n_miss++; $display("FAIL rs_out: got %0d want 0", outstanding_o); end
        n_vec++; if (wb_valid_o !== 1'b0 || wb_o !== '0) begin n_miss++; $display("FAIL rs_wb: got %b/%h want 0/0", wb_valid_o, wb_o); end
        for (int k = 0; k < 2; k++) begin
            tick();
            n_vec++; if (wb_valid_o !== 1'b0) begin n_miss++; $display("FAIL rs_no_pulse: got %b want 0", wb_valid_o); end
        end
    endtask

    task automatic test_errors();
        wb_ready_i = 1'b1;
        apply_reset();
        do_commit(4'd7, 1'b0);
        n_vec++; if (err_o !== 1'b1) begin n_miss++; $display("FAIL err_commit_idle: got %b want 1", err_o); end
        n_vec++; if (outstanding_o !== 5'd0) begin n_miss++; $display("FAIL err_commit_out: got %0d want 0", outstanding_o); end
        apply_reset();
        n_vec++; if (err_o !== 1'b0) begin n_miss++; $display("FAIL err_rst_clear: got %b want 0", err_o); end
        do_issue(4'd6, 1'b1);
        set_result(4'd6, 32'h0066);
        tick();
        x_result_valid_i = 1'b0;
        n_vec++; if (err_o !== 1'b1) begin n_miss++; $display("FAIL err_res_issued: got %b want 1", err_o); end
        n_vec++; if (wb_valid_o !== 1'b0) begin n_miss++; $display("FAIL err_res_drop: got %b want 0", wb_valid_o); end
        n_vec++; if (outstanding_o !== 5'd1) begin n_miss++; $display("FAIL err_res_out: got %0d want 1", outstanding_o); end
        tick();
        tick();
        n_vec++; if (err_o !== 1'b1) begin n_miss++; $display("FAIL err_sticky: got %b want 1", err_o); end
        apply_reset();
        do_issue(4'd4, 1'b1);
        do_issue(4'd4, 1'b0);
        n_vec++; if (err_o !== 1'b1) begin n_miss++; $display("FAIL err_reissue: got %b want 1", err_o); end
        n_vec++; if (outstanding_o !== 5'd1) begin n_miss++; $display("FAIL err_reissue_out: got %0d want 1", outstanding_o); end
    endtask

    initial begin
        rst_ni = 1'b0;
        issue_valid_i = 1'b0; issue_ready_i = 1'b0; issue_accept_i = 1'b0;
        issue_writeback_i = 1'b0; issue_id_i = '0;
        commit_valid_i = 1'b0; commit_id_i = '0; commit_kill_i = 1'b0;
        x_result_valid_i = 1'b0; x_result_i = '0;
        flush_i = 1'b0; wb_ready_i = 1'b0;
        tick();
        test_reset();
        test_forward();
        test_kill();
        test_back_to_back();
        test_full();
        test_flush();
        test_errors();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
